ft245_frame_sender: RTL and testbench

- Downstream stage of the ADC capture block. Starts on the capture block's one-cycle done pulse and reads the full capture RAM through its read port, word by word.
- Each 16-bit word is sent as two bytes over the FT245 asynchronous write interface to the USB host.
- Owns all FT245 write-side timing: TXE# synchronisation, data setup, WR pulse width and post-write recovery.

---
 rtl/ft245_frame_sender.sv | 217 +++++++++++++++++++++
 tb/tb_ft245_frame_sender.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_frame_sender.sv
// ft245_frame_sender
//   Reads a full frame from the capture RAM after a START pulse. Each 16-bit
//   word goes out as two bytes, low byte first, on the FT245 asynchronous
//   write interface. The block owns TXE# synchronisation, data setup, the WR
//   pulse width, data hold and post-write recovery.
//   Optional build macro FT245_FRAME_HEADER_EN: the frame is sent as a 0xA5
//   byte, a 0x5A byte, the payload, then a byte holding the modulo-256 sum of
//   all payload bytes.
// Ports:
//   CLK          system clock
//   RST          asynchronous reset, active-low
//   START        one-cycle frame start pulse (capture block done)
//   RAM_RD_ADDR  capture RAM read address
//   RAM_DATA_IN  capture RAM read data (RAM_LAT cycles after address)
//   FT_TXE_N     FT245 TXE#, asynchronous, low = space available
//   FT_DATA      byte to FT245
//   FT_DATA_OE   tristate enable for FT_DATA pads
//   FT_WR        FT245 WR strobe, byte latched on its falling edge
//   BUSY         high while a frame is in progress
//   DONE         one-cycle pulse after the last byte of a frame
module ft245_frame_sender #(
  parameter int ADDR_W      = 10,
  parameter int WORD_NUM    = 1024,
  parameter int RAM_LAT     = 1,
  parameter int SETUP_CYC   = 2,
  parameter int WR_CYC      = 4,
  parameter int HOLD_CYC    = 2,
  parameter int RECOVER_CYC = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic [ADDR_W-1:0] RAM_RD_ADDR,
  input  logic [15:0]       RAM_DATA_IN,
  input  logic              FT_TXE_N,
  output logic [7:0]        FT_DATA,
  output logic              FT_DATA_OE,
  output logic              FT_WR,
  output logic              BUSY,
  output logic              DONE
);

  localparam int CW = 8;

  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD, WAIT_TXE, SETUP, STROBE, HOLD, RECOVER, FINISH
  } state_t;

  state_t            state, nstate;
  logic [CW-1:0]     cnt;
  logic              cnt_done;
  logic              txe_m, txe_s;
  logic [ADDR_W-1:0] addr;
  logic              byte_sel;
  logic [15:0]       word;
  logic [7:0]        data;
  logic [7:0]        tx_byte;
  logic              at_end;
  logic              frame_last;
  logic              word_next;

`ifdef FT245_FRAME_HEADER_EN
  typedef enum logic [1:0] {PH_HDR0, PH_HDR1, PH_PAY, PH_CSUM} phase_t;
  phase_t     phase;
  logic [7:0] sum;
`endif

  // Cycles spent in a timed state, minus one.
  function automatic logic [CW-1:0] dur(input state_t s);
    case (s)
      FETCH:   dur = (RAM_LAT > 0) ? CW'(RAM_LAT - 1) : '0;
      SETUP:   dur = CW'(SETUP_CYC - 1);
      STROBE:  dur = CW'(WR_CYC - 1);
      HOLD:    dur = CW'(HOLD_CYC - 1);
      RECOVER: dur = CW'(RECOVER_CYC - 1);
      default: dur = '0;
    endcase
  endfunction

  assign cnt_done = (cnt == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      txe_m <= 1'b1;
      txe_s <= 1'b1;
    end else begin
      txe_m <= FT_TXE_N;
      txe_s <= txe_m;
    end
  end

  // Frame position decode and selection of the byte to transmit.
  always_comb begin
    at_end = (addr == ADDR_W'(WORD_NUM - 1));
`ifdef FT245_FRAME_HEADER_EN
    frame_last = (phase == PH_CSUM);
    word_next  = (phase == PH_PAY) && byte_sel && !at_end;
    case (phase)
      PH_HDR0: tx_byte = 8'hA5;
      PH_HDR1: tx_byte = 8'h5A;
      PH_CSUM: tx_byte = sum;
      default: tx_byte = byte_sel ? word[15:8] : word[7:0];
    endcase
`else
    frame_last = byte_sel && at_end;
    word_next  = byte_sel && !at_end;
    tx_byte    = byte_sel ? word[15:8] : word[7:0];
`endif
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    case (state)
      IDLE:     if (START) nstate = FETCH;
      FETCH:    if (cnt_done) nstate = LOAD;
      LOAD:     nstate = WAIT_TXE;
      WAIT_TXE: if (!txe_s) nstate = SETUP;
      SETUP:    if (cnt_done) nstate = STROBE;
      STROBE:   if (cnt_done) nstate = HOLD;
      HOLD:     if (cnt_done) nstate = RECOVER;
      RECOVER: begin
        if (cnt_done) begin
          if (frame_last)     nstate = FINISH;
          else if (word_next) nstate = FETCH;
          else                nstate = WAIT_TXE;
        end
      end
      FINISH:   nstate = IDLE;
      default:  nstate = IDLE;
    endcase
  end

  // Datapath: timers, address/byte position, word and byte registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt      <= '0;
      addr     <= '0;
      byte_sel <= 1'b0;
      word     <= '0;
      data     <= '0;
`ifdef FT245_FRAME_HEADER_EN
      phase    <= PH_HDR0;
      sum      <= '0;
`endif
    end else begin
      // Every timed state is entered from a different state, so a state
      // change is the reload point for the shared timer.
      if (nstate != state) cnt <= dur(nstate);
      else if (!cnt_done)  cnt <= cnt - CW'(1);

      case (state)
        IDLE: begin
          if (START) begin
            addr     <= '0;
            byte_sel <= 1'b0;
`ifdef FT245_FRAME_HEADER_EN
            phase    <= PH_HDR0;
            sum      <= '0;
`endif
          end
        end
        LOAD: word <= RAM_DATA_IN;
        WAIT_TXE: begin
          if (!txe_s) begin
            data <= tx_byte;
`ifdef FT245_FRAME_HEADER_EN
            if (phase == PH_PAY) sum <= sum + tx_byte;
`endif
          end
        end
        RECOVER: begin
          if (cnt_done) begin
            if (frame_last) begin
              addr <= '0;
            end else if (word_next) begin
              addr     <= addr + ADDR_W'(1);
              byte_sel <= 1'b0;
            end else begin
`ifdef FT245_FRAME_HEADER_EN
              if (phase == PH_PAY) byte_sel <= 1'b1;
`else
              byte_sel <= 1'b1;
`endif
            end
`ifdef FT245_FRAME_HEADER_EN
            case (phase)
              PH_HDR0: phase <= PH_HDR1;
              PH_HDR1: phase <= PH_PAY;
              PH_PAY:  if (byte_sel && at_end) phase <= PH_CSUM;
              default: ;
            endcase
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the state register, so reset drops FT_WR at once.
  always_comb begin
    RAM_RD_ADDR = addr;
    FT_DATA     = data;
    FT_DATA_OE  = (state == SETUP) || (state == STROBE) || (state == HOLD);
    FT_WR       = (state == STROBE);
    BUSY        = (state != IDLE) && (state != FINISH);
    DONE        = (state == FINISH);
  end

endmodule

// File: tb/tb_ft245_frame_sender.sv
module tb_ft245_frame_sender;

  localparam int AW  = 10;
  localparam int WN  = 4;
  localparam int SC  = 2;
  localparam int WC  = 4;
  localparam int HC  = 2;
  localparam int RC  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] ram_rd_addr;
  logic [15:0]   ram_q = '0;
  logic          txe_n = 1'b0;
  logic [7:0]    ft_data;
  logic          ft_data_oe;
  logic          ft_wr;
  logic          busy;
  logic          done;

  ft245_frame_sender #(
    .ADDR_W(AW), .WORD_NUM(WN), .RAM_LAT(1), .SETUP_CYC(SC),
    .WR_CYC(WC), .HOLD_CYC(HC), .RECOVER_CYC(RC)
  ) dut (
    .CLK(clk), .RST(rst), .START(start), .RAM_RD_ADDR(ram_rd_addr),
    .RAM_DATA_IN(ram_q), .FT_TXE_N(txe_n), .FT_DATA(ft_data),
    .FT_DATA_OE(ft_data_oe), .FT_WR(ft_wr), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  // Capture RAM: synchronous read, one cycle latency.
  logic [15:0] mem [0:1023];
  always @(posedge clk) ram_q <= mem[ram_rd_addr];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- bus monitor: byte capture + WR timing ----------------
  logic [7:0] rx [$];
  int         done_cnt = 0;
  logic       prev_wr = 0, prev_oe = 0;
  logic [7:0] prev_data = '0, rise_data = '0, hold_data = '0;
  int         stable = 0, wr_len = 0, hold_len = 0;
  bit         in_hold = 0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_wr = 0; prev_oe = 0; stable = 0; wr_len = 0; in_hold = 0;
    end else begin
      if (ft_wr && !prev_wr) begin
        check("setup_time", {31'd0, (stable >= SC) && (ft_data == prev_data)}, 1);
        rise_data = ft_data;
        wr_len = 1;
      end else if (ft_wr) begin
        wr_len++;
      end
      if (!ft_wr && prev_wr) begin
        check("wr_width", wr_len, WC);
        check("data_during_wr", ft_data, rise_data);
        check("busy_in_frame", busy, 1);
        rx.push_back(ft_data);
        in_hold = 1; hold_data = ft_data; hold_len = 0;
      end
      if (in_hold) begin
        if (ft_data_oe && ft_data == hold_data) hold_len++;
        else begin
          check("hold_time", {31'd0, hold_len >= HC}, 1);
          in_hold = 0;
        end
      end
      if (ft_data_oe && prev_oe && ft_data == prev_data) stable++;
      else stable = ft_data_oe ? 1 : 0;
      if (done) begin
        done_cnt++;
        check("done_busy_low", busy, 0);
        check("done_addr_zero", ram_rd_addr, 0);
      end
      prev_wr = ft_wr; prev_oe = ft_data_oe; prev_data = ft_data;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] exp_q [$];

  // Adds the optional framing bytes around whatever payload exp_q holds.
  task automatic wrap_frame();
`ifdef FT245_FRAME_HEADER_EN
    logic [7:0] s = '0;
    foreach (exp_q[i]) s = s + exp_q[i];
    exp_q.push_front(8'h5A);
    exp_q.push_front(8'hA5);
    exp_q.push_back(s);
`endif
  endtask

  // Payload from RAM contents: ascending words, low byte first.
  task automatic model_from_mem();
    exp_q.delete();
    for (int k = 0; k < WN; k++) begin
      exp_q.push_back(mem[k] & 16'h00FF);
      exp_q.push_back(mem[k] >> 8);
    end
    wrap_frame();
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, rx.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), rx[i], exp_q[i]);
  endtask

  // mode: 0 TXE low, 1 TXE stall before byte 3, 2 START re-pulse, 3 random TXE
  task automatic run_frame(input int mode, input string tag);
    int  stall_left = -1;
    int  stall_cyc  = 0;
    int  viol       = 0;
    int  rx_at_stall = 0;
    bit  restarted  = 0;
    rx.delete();
    done_cnt = 0;
    txe_n = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    for (int c = 0; c < 6000 && done_cnt == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      case (mode)
        1: begin
          if (stall_left < 0 && rx.size() == 2) begin
            txe_n = 1'b1; stall_left = 50; rx_at_stall = rx.size();
          end else if (stall_left > 0) begin
            stall_left--; stall_cyc++;
            if (stall_cyc > 10 && (ft_wr || ft_data_oe)) viol++;
            if (stall_left == 0) begin
              check({tag, "_stall_quiet"}, viol, 0);
              check({tag, "_stall_no_byte"}, rx.size(), rx_at_stall);
              txe_n = 1'b0;
            end
          end
        end
        2: if (!restarted && rx.size() == 2) begin start = 1'b1; restarted = 1; end
        3: txe_n = ($urandom_range(0, 3) == 0);
        default: ;
      endcase
    end
    txe_n = 1'b0;
    check({tag, "_done_seen"}, {31'd0, done_cnt > 0}, 1);
    repeat (30) @(negedge clk);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_idle_busy"}, busy, 0);
    compare_frame(tag);
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic [3:0][15:0] w;       // RAM words 0..3
    logic [31:0]      mode;
    logic [7:0][7:0]  exp_pl;  // payload bytes in send order, [0] first
  } vec_t;

  vec_t vt [4];

  initial begin
    vt[0] = '{w: 64'h0A03_0A02_0A01_0A00, mode: 0, exp_pl: {8'h0A,8'h03,8'h0A,8'h02,8'h0A,8'h01,8'h0A,8'h00}};
    vt[1] = '{w: 64'h0A03_0A02_0A01_0A00, mode: 1, exp_pl: {8'h0A,8'h03,8'h0A,8'h02,8'h0A,8'h01,8'h0A,8'h00}};
    vt[2] = '{w: 64'h0A03_0A02_0A01_0A00, mode: 2, exp_pl: {8'h0A,8'h03,8'h0A,8'h02,8'h0A,8'h01,8'h0A,8'h00}};
    vt[3] = '{w: 64'h8001_F0FF_0304_0102, mode: 0, exp_pl: {8'h80,8'h01,8'hF0,8'hFF,8'h03,8'h04,8'h01,8'h02}};

    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_addr", ram_rd_addr, 0);
    check("rst_data", ft_data, 0);
    check("rst_oe", ft_data_oe, 0);
    check("rst_wr", ft_wr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < WN; k++) mem[k] = vt[t].w[k];
      exp_q.delete();
      for (int b = 0; b < 2 * WN; b++) exp_q.push_back(vt[t].exp_pl[b]);
      wrap_frame();
      run_frame(int'(vt[t].mode), $sformatf("vec%0d", t));
    end

    // Reset during STROBE of byte 5, then a complete new frame.
    for (int k = 0; k < WN; k++) mem[k] = vt[0].w[k];
    rx.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    begin
      int c = 0;
      while ((rx.size() < 4 || !ft_wr) && c < 3000) begin @(negedge clk); c++; end
      check("rst_test_reach_strobe", {31'd0, c < 3000}, 1);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_wr", ft_wr, 0);
    check("midrst_oe", ft_data_oe, 0);
    check("midrst_data", ft_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_addr", ram_rd_addr, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", busy, 0);
    check("post_rst_no_bytes", rx.size(), 4);
    exp_q.delete();
    for (int b = 0; b < 2 * WN; b++) exp_q.push_back(vt[0].exp_pl[b]);
    wrap_frame();
    run_frame(0, "after_rst");

    // Randomised RAM contents and TXE# activity against the model.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < WN; k++) mem[k] = 16'($urandom);
      model_from_mem();
      run_frame(3, $sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
